// File: rtl/serial_adc_pkg.sv
// Shared types and constants for the serial ADC sequencer: FSM states,
// SCLK half-period options and the default frame layout.
package serial_adc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CS_SETUP,
        ST_SHIFT,
        ST_GAP
    } adc_state_t;

    localparam int HALF_128 = 128;
    localparam int HALF_64  = 64;
    localparam int HALF_32  = 32;
    localparam int HALF_16  = 16;
    localparam int HALF_W   = 8;

    localparam int DEF_CFG_BITS   = 5;
    localparam int DEF_NULL_BITS  = 1;
    localparam int DEF_DATA_BITS  = 12;
    localparam int DEF_GAP_HALVES = 2;

    function automatic logic [HALF_W-1:0] half_of(input logic [1:0] sel);
        logic [HALF_W-1:0] h;
        case (sel)
            2'b00:   h = HALF_W'(HALF_128);
            2'b01:   h = HALF_W'(HALF_64);
            2'b10:   h = HALF_W'(HALF_32);
            default: h = HALF_W'(HALF_16);
        endcase
        return h;
    endfunction

endpackage

// File: rtl/serial_adc_sequencer_sclk_tick_gen.sv
// Half-period tick generator: the half-period length is captured on i_load and
// o_tick pulses for one cycle at the end of every half-period.
module sclk_tick_gen
    import serial_adc_pkg::*;
(
    input  logic       clk_in,
    input  logic       reset,
    input  logic       i_clear,
    input  logic       i_load,
    input  logic [1:0] i_freq_sel,
    output logic       o_tick
);

    logic [HALF_W-1:0] r_half;
    logic [HALF_W-1:0] r_count;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_half  <= HALF_W'(HALF_128);
            r_count <= '0;
        end else begin
            if (i_load) begin
                r_half <= half_of(i_freq_sel);
            end
            if (i_clear || o_tick) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign o_tick = (r_count == (r_half - 1'b1));

endmodule

// File: rtl/serial_adc_sequencer.sv
// Frame sequencer for an SPI-style ADC: shifts a config word out on din,
// captures the conversion result from dout, and paces frames with cs_n.
module serial_adc_sequencer
    import serial_adc_pkg::*;
#(
    parameter int CFG_BITS   = DEF_CFG_BITS,
    parameter int NULL_BITS  = DEF_NULL_BITS,
    parameter int DATA_BITS  = DEF_DATA_BITS,
    parameter int GAP_HALVES = DEF_GAP_HALVES
)(
    input  logic                 clk_in,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 continuous,
    input  logic [1:0]           freq_sel,
    input  logic [2:0]           channel,
    input  logic                 single_ended,
    input  logic                 adc_dout,
    output logic                 adc_cs_n,
    output logic                 adc_sclk,
    output logic                 adc_din,
    output logic [DATA_BITS-1:0] sample,
    output logic [2:0]           sample_ch,
    output logic                 sample_valid,
    output logic                 busy,
    output logic                 overrun
);

    localparam int SHIFT_HALVES = 2 * (CFG_BITS + NULL_BITS + DATA_BITS);
    localparam int PH_W         = $clog2(SHIFT_HALVES + GAP_HALVES + 1);
    localparam logic [PH_W-1:0] PH_SHIFT_LAST = PH_W'(SHIFT_HALVES - 1);
    localparam logic [PH_W-1:0] PH_GAP_LAST   = PH_W'(GAP_HALVES - 1);
    localparam logic [PH_W-1:0] CAP_FROM      = PH_W'(2 * (CFG_BITS + NULL_BITS));
    localparam logic [PH_W-1:0] CFG_LIM       = PH_W'((CFG_BITS < 5) ? CFG_BITS : 5);

    adc_state_t           r_state, w_state_next;
    logic [PH_W-1:0]      r_phase, w_phase_next;
    logic [DATA_BITS-1:0] r_shift, w_shift_next;
    logic [DATA_BITS-1:0] r_sample, w_sample_next;
    logic [2:0]           r_ch, w_ch_next, r_sample_ch, w_sample_ch_next;
    logic                 r_sgl, w_sgl_next, r_pending, w_pending_next;
    logic                 r_cs_n, w_cs_n_next, r_sclk, w_sclk_next;
    logic                 r_din, w_din_next, r_valid, w_valid_next;
    logic                 r_busy, w_busy_next, r_overrun, w_overrun_next;
    logic                 w_tick, w_entry, w_setup_entry, w_start_busy, w_req;
    logic [PH_W-1:0]      w_fall_idx;
    logic [7:0]           w_cfg;

    sclk_tick_gen u_tick (
        .clk_in     (clk_in),
        .reset      (reset),
        .i_clear    (w_entry),
        .i_load     (w_setup_entry),
        .i_freq_sel (freq_sel),
        .o_tick     (w_tick)
    );

    // Config word in shift order: index 0 is the start bit.
    assign w_cfg        = {3'b000, r_ch[0], r_ch[1], r_ch[2], r_sgl, 1'b1};
    assign w_fall_idx   = (r_phase + 1'b1) >> 1;
    assign w_start_busy = start && (r_state != ST_IDLE);
    assign w_req        = r_pending || w_start_busy;

    always_comb begin
        w_state_next     = r_state;
        w_phase_next     = r_phase;
        w_shift_next     = r_shift;
        w_sample_next    = r_sample;
        w_sample_ch_next = r_sample_ch;
        w_ch_next        = r_ch;
        w_sgl_next       = r_sgl;
        w_sclk_next      = 1'b0;
        w_din_next       = 1'b0;
        w_valid_next     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_next = ST_CS_SETUP;
            end
            ST_CS_SETUP: begin
                w_din_next = 1'b1;
                if (w_tick) w_state_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                w_sclk_next = r_sclk;
                w_din_next  = r_din;
                if (w_tick) begin
                    w_sclk_next  = ~r_sclk;
                    w_phase_next = r_phase + 1'b1;
                    if (!r_sclk) begin
                        if (r_phase >= CAP_FROM) w_shift_next = {r_shift[DATA_BITS-2:0], adc_dout};
                    end else begin
                        w_din_next = (w_fall_idx < CFG_LIM) ? w_cfg[w_fall_idx[2:0]] : 1'b0;
                    end
                    if (r_phase == PH_SHIFT_LAST) begin
                        w_state_next     = ST_GAP;
                        w_sample_next    = r_shift;
                        w_sample_ch_next = r_ch;
                        w_valid_next     = 1'b1;
                        w_din_next       = 1'b0;
                    end
                end
            end
            ST_GAP: begin
                if (w_tick) begin
                    w_phase_next = r_phase + 1'b1;
                    // continuous is sampled here, the same moment the next frame latches its setup
                    if (r_phase == PH_GAP_LAST) w_state_next = (continuous || w_req) ? ST_CS_SETUP : ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
        w_entry       = (w_state_next != r_state);
        w_setup_entry = w_entry && (w_state_next == ST_CS_SETUP);
        if (w_entry) w_phase_next = '0;
        if (w_setup_entry) begin
            w_ch_next  = channel;
            w_sgl_next = single_ended;
            w_din_next = 1'b1;
        end
        w_pending_next = w_setup_entry ? (r_pending && w_start_busy) : w_req;
        w_overrun_next = w_start_busy && r_pending && !w_setup_entry;
        w_cs_n_next    = (w_state_next == ST_IDLE) || (w_state_next == ST_GAP);
        w_busy_next    = (w_state_next != ST_IDLE);
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_phase     <= '0;
            r_shift     <= '0;
            r_sample    <= '0;
            r_sample_ch <= '0;
            r_ch        <= '0;
            r_sgl       <= 1'b0;
            r_pending   <= 1'b0;
            r_cs_n      <= 1'b1;
            r_sclk      <= 1'b0;
            r_din       <= 1'b0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_phase     <= w_phase_next;
            r_shift     <= w_shift_next;
            r_sample    <= w_sample_next;
            r_sample_ch <= w_sample_ch_next;
            r_ch        <= w_ch_next;
            r_sgl       <= w_sgl_next;
            r_pending   <= w_pending_next;
            r_cs_n      <= w_cs_n_next;
            r_sclk      <= w_sclk_next;
            r_din       <= w_din_next;
            r_valid     <= w_valid_next;
            r_busy      <= w_busy_next;
            r_overrun   <= w_overrun_next;
        end
    end

    assign adc_cs_n     = r_cs_n;
    assign adc_sclk     = r_sclk;
    assign adc_din      = r_din;
    assign sample       = r_sample;
    assign sample_ch    = r_sample_ch;
    assign sample_valid = r_valid;
    assign busy         = r_busy;
    assign overrun      = r_overrun;

endmodule
